// File: rtl/exc_pc_ctrl.sv
// Exception/return sequencer in front of the PC-source mux: passes control selects through in IDLE, runs SAVE/WAIT/LOAD on exceptions and RET on eret.
// Latency: exception edge to pc_write = MEM_LATENCY+1 cycles, eret = 1 cycle; no backpressure, requests outside IDLE are dropped.
module exc_pc_ctrl #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] VEC_BASE    = 32'd253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  pc_src_req,
    input  logic        pc_write_req,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        eret,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  pc_src_sel,
    output logic        pc_write,
    output logic [31:0] epc_out,
    output logic [31:0] mem_addr,
    output logic        mem_addr_ovr,
    output logic [31:0] handler_addr,
    output logic [1:0]  cause,
    output logic        exc_busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SAVE = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        RET  = 3'd4
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        exc_any;
    logic [1:0]  cause_nxt;
    logic [2:0]  sel_c;
    logic        write_c;
    logic        ovr_c;
    logic        unused_mem_hi;

    assign exc_any = exc_opcode | exc_overflow | exc_div0;

    always_comb begin
        cause_nxt = 2'd0;
        if (exc_opcode)
            cause_nxt = 2'd1;
        else if (exc_overflow)
            cause_nxt = 2'd2;
        else if (exc_div0)
            cause_nxt = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            epc_out  <= 32'd0;
            cause    <= 2'd0;
            mem_addr <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && exc_any) begin
                cause    <= cause_nxt;
                epc_out  <= pc_in - 32'd4;
                mem_addr <= VEC_BASE + {30'd0, cause_nxt} - 32'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_c     = 3'b000;
        write_c   = 1'b0;
        ovr_c     = 1'b0;
        case (state)
            IDLE: begin
                sel_c   = pc_src_req;
                write_c = pc_write_req;
                // exception has priority over a simultaneous eret
                if (exc_any)
                    state_nxt = SAVE;
                else if (eret)
                    state_nxt = RET;
            end
            SAVE: begin
                ovr_c     = 1'b1;
                cnt_nxt   = CNT_INIT;
                state_nxt = (MEM_LATENCY <= 1) ? LOAD : WAIT;
            end
            WAIT: begin
                ovr_c   = 1'b1;
                cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1)
                    state_nxt = LOAD;
            end
            LOAD: begin
                ovr_c     = 1'b1;
                sel_c     = 3'b101;
                write_c   = 1'b1;
                state_nxt = IDLE;
            end
            RET: begin
                sel_c     = 3'b011;
                write_c   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pass-through is gated by reset so a held pc_write_req cannot write PC during reset
    assign pc_src_sel    = reset ? sel_c : 3'b000;
    assign pc_write      = reset & write_c;
    assign mem_addr_ovr  = reset & ovr_c;
    assign exc_busy      = (state != IDLE);
    assign handler_addr  = {24'd0, mem_data_in[7:0]};
    assign unused_mem_hi = ^mem_data_in[31:8];

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Directed bench for exc_pc_ctrl: one instance with MEM_LATENCY=2, one with MEM_LATENCY=1, sharing stimulus.
module tb_exc_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pc_src_req;
    logic        pc_write_req;
    logic        exc_opcode, exc_overflow, exc_div0, eret;
    logic [31:0] pc_in, mem_data_in;

    logic [2:0]  sel2, sel1;
    logic        wr2, wr1, ovr2, ovr1, busy2, busy1;
    logic [31:0] epc2, epc1, ma2, ma1, ha2, ha1;
    logic [1:0]  cause2, cause1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exc_pc_ctrl #(.MEM_LATENCY(2), .VEC_BASE(32'd253)) dut2 (
        .clk(clk), .reset(reset), .pc_src_req(pc_src_req), .pc_write_req(pc_write_req),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0), .eret(eret),
        .pc_in(pc_in), .mem_data_in(mem_data_in), .pc_src_sel(sel2), .pc_write(wr2),
        .epc_out(epc2), .mem_addr(ma2), .mem_addr_ovr(ovr2), .handler_addr(ha2),
        .cause(cause2), .exc_busy(busy2)
    );

    exc_pc_ctrl #(.MEM_LATENCY(1), .VEC_BASE(32'd253)) dut1 (
        .clk(clk), .reset(reset), .pc_src_req(pc_src_req), .pc_write_req(pc_write_req),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0), .eret(eret),
        .pc_in(pc_in), .mem_data_in(mem_data_in), .pc_src_sel(sel1), .pc_write(wr1),
        .epc_out(epc1), .mem_addr(ma1), .mem_addr_ovr(ovr1), .handler_addr(ha1),
        .cause(cause1), .exc_busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; pc_src_req = 3'b110; pc_write_req = 1'b1;
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0; eret = 0;
        pc_in = 32'd0; mem_data_in = 32'd0;

        // reset values, pass-through gated while reset is low
        tick();
        check("rst_epc", epc2, 32'd0);
        check("rst_cause", {30'd0, cause2}, 32'd0);
        check("rst_mem_addr", ma2, 32'd0);
        check("rst_ovr", {31'd0, ovr2}, 32'd0);
        check("rst_pc_write", {31'd0, wr2}, 32'd0);
        check("rst_sel", {29'd0, sel2}, 32'd0);
        check("rst_busy", {31'd0, busy2}, 32'd0);
        #3 reset = 1'b1;
        tick();

        // overflow exception, MEM_LATENCY=2
        pc_in = 32'h44; pc_src_req = 3'b001; pc_write_req = 1'b1; exc_overflow = 1'b1;
        #1;
        check("idle_pass_sel", {29'd0, sel2}, 32'd1);
        check("idle_pass_wr", {31'd0, wr2}, 32'd1);
        tick();
        exc_overflow = 1'b0;
        check("ovf_epc", epc2, 32'h40);
        check("ovf_cause", {30'd0, cause2}, 32'd2);
        check("ovf_mem_addr", ma2, 32'd254);
        check("save_ovr", {31'd0, ovr2}, 32'd1);
        check("save_wr", {31'd0, wr2}, 32'd0);
        check("save_sel", {29'd0, sel2}, 32'd0);
        check("save_busy", {31'd0, busy2}, 32'd1);
        tick();
        check("wait_ovr", {31'd0, ovr2}, 32'd1);
        check("wait_wr", {31'd0, wr2}, 32'd0);
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        mem_data_in = 32'h1A8;
        #1;
        check("load_ovr", {31'd0, ovr2}, 32'd1);
        check("load_sel", {29'd0, sel2}, 32'd5);
        check("load_wr", {31'd0, wr2}, 32'd1);
        check("handler", ha2, 32'hA8);
        tick();
        check("post_ovr", {31'd0, ovr2}, 32'd0);
        check("post_busy", {31'd0, busy2}, 32'd0);
        check("div0_ignored_cause", {30'd0, cause2}, 32'd2);
        check("div0_ignored_epc", epc2, 32'h40);

        // eret returns through EPC
        eret = 1'b1;
        #1;
        check("eret_idle_sel", {29'd0, sel2}, 32'd1);
        tick();
        eret = 1'b0;
        check("ret_sel", {29'd0, sel2}, 32'd3);
        check("ret_wr", {31'd0, wr2}, 32'd1);
        check("ret_epc", epc2, 32'h40);
        check("ret_ovr", {31'd0, ovr2}, 32'd0);
        tick();
        pc_src_req = 3'b010; pc_write_req = 1'b0;
        #1;
        check("after_ret_sel", {29'd0, sel2}, 32'd2);
        check("after_ret_wr", {31'd0, wr2}, 32'd0);
        check("after_ret_busy", {31'd0, busy2}, 32'd0);

        // all three exceptions at once
        pc_in = 32'h64; exc_opcode = 1'b1; exc_overflow = 1'b1; exc_div0 = 1'b1;
        tick();
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
        check("prio_cause", {30'd0, cause2}, 32'd1);
        check("prio_mem_addr", ma2, 32'd253);
        check("prio_epc", epc2, 32'h60);
        tick(); tick(); tick();
        check("prio_done_busy", {31'd0, busy2}, 32'd0);

        // eret together with exception: exception only
        pc_in = 32'h200; eret = 1'b1; exc_opcode = 1'b1;
        tick();
        eret = 1'b0; exc_opcode = 1'b0;
        check("sim_sel", {29'd0, sel2}, 32'd0);
        check("sim_wr", {31'd0, wr2}, 32'd0);
        check("sim_ovr", {31'd0, ovr2}, 32'd1);
        check("sim_cause", {30'd0, cause2}, 32'd1);
        check("sim_epc", epc2, 32'h1FC);
        tick(); tick();
        check("sim_load_sel", {29'd0, sel2}, 32'd5);
        tick();
        check("sim_no_ret_busy", {31'd0, busy2}, 32'd0);
        check("sim_no_ret_wr", {31'd0, wr2}, 32'd0);

        // reset during WAIT
        pc_in = 32'h80; exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        check("div0_cause", {30'd0, cause2}, 32'd3);
        check("div0_mem_addr", ma2, 32'd255);
        tick();
        pc_src_req = 3'b010; pc_write_req = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("abort_epc", epc2, 32'd0);
        check("abort_cause", {30'd0, cause2}, 32'd0);
        check("abort_mem_addr", ma2, 32'd0);
        check("abort_ovr", {31'd0, ovr2}, 32'd0);
        check("abort_wr", {31'd0, wr2}, 32'd0);
        check("abort_sel", {29'd0, sel2}, 32'd0);
        check("abort_busy", {31'd0, busy2}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("rel_pass_sel", {29'd0, sel2}, 32'd2);
        check("rel_pass_wr", {31'd0, wr2}, 32'd1);
        tick();
        check("rel_edge_sel", {29'd0, sel2}, 32'd2);
        check("rel_edge_busy", {31'd0, busy2}, 32'd0);

        // pc_in=0 wrap, MEM_LATENCY=1 goes SAVE->LOAD
        pc_write_req = 1'b0; pc_in = 32'd0; exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        check("wrap_epc", epc1, 32'hFFFF_FFFC);
        check("l1_cause", {30'd0, cause1}, 32'd1);
        check("l1_save_wr", {31'd0, wr1}, 32'd0);
        check("l1_save_ovr", {31'd0, ovr1}, 32'd1);
        tick();
        check("l1_load_wr", {31'd0, wr1}, 32'd1);
        check("l1_load_sel", {29'd0, sel1}, 32'd5);
        check("l2_wait_wr", {31'd0, wr2}, 32'd0);
        tick();
        check("l1_idle_busy", {31'd0, busy1}, 32'd0);
        check("l2_load_wr", {31'd0, wr2}, 32'd1);
        tick();
        check("l2_idle_busy", {31'd0, busy2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
